obi_mem_arbiter: RTL and testbench

Shares one OBI memory port between the core's instruction-fetch and data-access OBI interfaces, so both can be served by a single-port memory model or SRAM. It sits between `cv32e40x_core_with_aes` and the memory. It arbitrates requests, tracks the source of each outstanding transaction in order, and routes each in-order response back to the interface that issued it.

---
 rtl/obi_arb_pkg.sv | 16 +
 rtl/obi_arb_src_fifo.sv | 70 +++++++
 rtl/obi_mem_arbiter.sv | 128 ++++++++++++
 tb/tb_obi_mem_arbiter.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/obi_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : obi_arb_pkg
//  Brief   : Shared types and default constants for the OBI memory arbiter.
//  Revision: 1.0
// ============================================================================
package obi_arb_pkg;

    typedef enum logic {SRC_INSTR = 1'b0, SRC_DATA = 1'b1} obi_src_e;

    localparam int unsigned c_ADDR_WIDTH      = 32;
    localparam int unsigned c_DATA_WIDTH      = 32;
    localparam int unsigned c_MAX_OUTSTANDING = 2;

endpackage
`default_nettype wire

// File: rtl/obi_arb_src_fifo.sv
`default_nettype none
// ============================================================================
//  Module  : obi_arb_src_fifo
//  Brief   : In-order FIFO of request source IDs, async active-low reset.
//  Revision: 1.0
// ============================================================================
module obi_arb_src_fifo
    import obi_arb_pkg::*;
#(
    parameter int unsigned DEPTH = c_MAX_OUTSTANDING
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     push_i,
    input  obi_src_e src_i,
    input  logic     pop_i,
    output logic     full_o,
    output logic     empty_o,
    output obi_src_e head_o
);

    localparam int unsigned c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned c_CNT_W = $clog2(DEPTH + 1);

    obi_src_e             r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wptr;
    logic [c_PTR_W-1:0]   r_rptr;
    logic [c_CNT_W-1:0]   r_count;

    logic w_push;
    logic w_pop;

    function automatic logic [c_PTR_W-1:0] next_ptr(input logic [c_PTR_W-1:0] ptr);
        return (ptr == c_PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign full_o  = (r_count == c_CNT_W'(DEPTH));
    assign empty_o = (r_count == '0);
    assign head_o  = r_mem[r_rptr];
    assign w_push  = push_i & ~full_o;
    assign w_pop   = pop_i & ~empty_o;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wptr] <= src_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= next_ptr(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= next_ptr(r_rptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/obi_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : obi_mem_arbiter
//  Brief   : Shares one OBI memory port between instruction and data ports.
//            OBI_ARB_ROUND_ROBIN_EN selects round-robin (else data priority).
//  Revision: 1.0
// ============================================================================
module obi_mem_arbiter
    import obi_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = c_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH      = c_DATA_WIDTH,
    parameter int unsigned MAX_OUTSTANDING = c_MAX_OUTSTANDING
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    instr_req_i,
    output logic                    instr_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
    output logic                    instr_rvalid_o,
    output logic                    instr_err_o,
    output logic [DATA_WIDTH-1:0]   instr_rdata_o,
    input  logic                    data_req_i,
    output logic                    data_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   data_addr_i,
    input  logic                    data_we_i,
    input  logic [DATA_WIDTH/8-1:0] data_be_i,
    input  logic [DATA_WIDTH-1:0]   data_wdata_i,
    output logic                    data_rvalid_o,
    output logic                    data_err_o,
    output logic [DATA_WIDTH-1:0]   data_rdata_o,
    output logic                    mem_req_o,
    input  logic                    mem_gnt_i,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic                    mem_we_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic                    mem_rvalid_i,
    input  logic                    mem_err_i,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
    output logic                    unexp_rsp_o
);

    obi_src_e r_last_src;
    logic     r_unexp;

    obi_src_e w_sel;
    obi_src_e w_head;
    logic     w_full;
    logic     w_empty;
    logic     w_hs;
    logic     w_rsp;

    always_comb begin
        w_sel = SRC_INSTR;
`ifdef OBI_ARB_ROUND_ROBIN_EN
        if (instr_req_i && data_req_i) begin
            w_sel = (r_last_src == SRC_INSTR) ? SRC_DATA : SRC_INSTR;
        end else if (data_req_i) begin
            w_sel = SRC_DATA;
        end
`else
        if (data_req_i) begin
            w_sel = SRC_DATA;
        end
`endif
    end

    // Payload stays zero when nobody requests, so idle outputs are all 0.
    always_comb begin
        mem_addr_o  = '0;
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_wdata_o = '0;
        if (w_sel == SRC_DATA && data_req_i) begin
            mem_addr_o  = data_addr_i;
            mem_we_o    = data_we_i;
            mem_be_o    = data_be_i;
            mem_wdata_o = data_wdata_i;
        end else if (instr_req_i) begin
            mem_addr_o  = instr_addr_i;
            mem_be_o    = '1;
        end
    end

    assign mem_req_o   = (instr_req_i | data_req_i) & ~w_full;
    assign w_hs        = mem_req_o & mem_gnt_i;
    assign instr_gnt_o = w_hs & (w_sel == SRC_INSTR);
    assign data_gnt_o  = w_hs & (w_sel == SRC_DATA);

    assign w_rsp          = mem_rvalid_i & ~w_empty;
    assign instr_rvalid_o = w_rsp & (w_head == SRC_INSTR);
    assign data_rvalid_o  = w_rsp & (w_head == SRC_DATA);
    assign instr_rdata_o  = instr_rvalid_o ? mem_rdata_i : '0;
    assign data_rdata_o   = data_rvalid_o ? mem_rdata_i : '0;
    assign instr_err_o    = instr_rvalid_o & mem_err_i;
    assign data_err_o     = data_rvalid_o & mem_err_i;
    assign unexp_rsp_o    = r_unexp;

    obi_arb_src_fifo #(
        .DEPTH   (MAX_OUTSTANDING)
    ) u_src_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (w_hs),
        .src_i   (w_sel),
        .pop_i   (mem_rvalid_i),
        .full_o  (w_full),
        .empty_o (w_empty),
        .head_o  (w_head)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_last_src <= SRC_DATA;
            r_unexp    <= 1'b0;
        end else begin
            if (w_hs) begin
                r_last_src <= w_sel;
            end
            if (mem_rvalid_i && w_empty) begin
                r_unexp <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_obi_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : tb_obi_mem_arbiter
//  Brief   : Directed vector bench for obi_mem_arbiter.
//  Revision: 1.0
// ============================================================================
module tb_obi_mem_arbiter;

`ifdef OBI_ARB_ROUND_ROBIN_EN
    localparam bit c_RR = 1'b1;
`else
    localparam bit c_RR = 1'b0;
`endif

    localparam logic [31:0] c_IA = 32'h0000_0040;
    localparam logic [31:0] c_DA = 32'h0000_0100;
    localparam logic [31:0] c_WD = 32'h0000_CAFE;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        instr_req_i = 1'b0, data_req_i = 1'b0;
    logic        instr_gnt_o, data_gnt_o;
    logic [31:0] instr_addr_i = c_IA, data_addr_i = c_DA;
    logic        data_we_i = 1'b1;
    logic [3:0]  data_be_i = 4'h3;
    logic [31:0] data_wdata_i = c_WD;
    logic        instr_rvalid_o, instr_err_o, data_rvalid_o, data_err_o;
    logic [31:0] instr_rdata_o, data_rdata_o;
    logic        mem_req_o, mem_gnt_i = 1'b0, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i = '0;
    logic [3:0]  mem_be_o;
    logic        mem_rvalid_i = 1'b0, mem_err_i = 1'b0;
    logic        unexp_rsp_o;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    obi_mem_arbiter u_dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .instr_req_i    (instr_req_i),
        .instr_gnt_o    (instr_gnt_o),
        .instr_addr_i   (instr_addr_i),
        .instr_rvalid_o (instr_rvalid_o),
        .instr_err_o    (instr_err_o),
        .instr_rdata_o  (instr_rdata_o),
        .data_req_i     (data_req_i),
        .data_gnt_o     (data_gnt_o),
        .data_addr_i    (data_addr_i),
        .data_we_i      (data_we_i),
        .data_be_i      (data_be_i),
        .data_wdata_i   (data_wdata_i),
        .data_rvalid_o  (data_rvalid_o),
        .data_err_o     (data_err_o),
        .data_rdata_o   (data_rdata_o),
        .mem_req_o      (mem_req_o),
        .mem_gnt_i      (mem_gnt_i),
        .mem_addr_o     (mem_addr_o),
        .mem_we_o       (mem_we_o),
        .mem_be_o       (mem_be_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_rvalid_i   (mem_rvalid_i),
        .mem_err_i      (mem_err_i),
        .mem_rdata_i    (mem_rdata_i),
        .unexp_rsp_o    (unexp_rsp_o)
    );

    typedef struct {
        logic        ir, dr, g, rv, er;
        logic [31:0] rd;
        logic        mreq, ig, dg, irv, drv, ierr, derr, unexp;
        logic [31:0] maddr, ird, drd;
    } vec_t;

    vec_t tbl [16];

    function automatic vec_t mk(input logic ir, dr, g, rv, er, input logic [31:0] rd,
                                input logic mreq, ig, dg, irv, drv, ierr, derr, unexp,
                                input logic [31:0] maddr, ird, drd);
        vec_t v;
        v.ir = ir; v.dr = dr; v.g = g; v.rv = rv; v.er = er; v.rd = rd;
        v.mreq = mreq; v.ig = ig; v.dg = dg; v.irv = irv; v.drv = drv;
        v.ierr = ierr; v.derr = derr; v.unexp = unexp;
        v.maddr = maddr; v.ird = ird; v.drd = drd;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s vec=%0d actual=%h required=%h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic ir, dr, g, rv, er, input logic [31:0] rd);
        instr_req_i = ir; data_req_i = dr; mem_gnt_i = g;
        mem_rvalid_i = rv; mem_err_i = er; mem_rdata_i = rd;
    endtask

    initial begin
        // Sequential vectors; FIFO occupancy and last source carry across rows.
        tbl[0]  = mk(0,0,0,0,0, 32'h0,        0,0,0,0,0,0,0,0, 32'h0, 32'h0, 32'h0);
        tbl[1]  = mk(0,1,1,0,0, 32'h0,        1,0,1,0,0,0,0,0, c_DA,  32'h0, 32'h0);
        tbl[2]  = mk(0,0,0,1,0, 32'hDEADBEEF, 0,0,0,0,1,0,0,0, 32'h0, 32'h0, 32'hDEADBEEF);
        tbl[3]  = mk(1,0,1,0,0, 32'h0,        1,1,0,0,0,0,0,0, c_IA,  32'h0, 32'h0);
        tbl[4]  = mk(0,1,1,0,0, 32'h0,        1,0,1,0,0,0,0,0, c_DA,  32'h0, 32'h0);
        tbl[5]  = mk(0,1,1,0,0, 32'h0,        0,0,0,0,0,0,0,0, c_DA,  32'h0, 32'h0);
        tbl[6]  = mk(0,1,1,1,0, 32'h11,       0,0,0,1,0,0,0,0, c_DA,  32'h11, 32'h0);
        tbl[7]  = mk(0,1,1,1,0, 32'h22,       1,0,1,0,1,0,0,0, c_DA,  32'h0, 32'h22);
        tbl[8]  = mk(0,0,0,1,1, 32'h33,       0,0,0,0,1,0,1,0, 32'h0, 32'h0, 32'h33);
        tbl[9]  = mk(0,0,0,1,0, 32'h44,       0,0,0,0,0,0,0,0, 32'h0, 32'h0, 32'h0);
        tbl[10] = mk(0,0,0,0,0, 32'h0,        0,0,0,0,0,0,0,1, 32'h0, 32'h0, 32'h0);
        tbl[11] = mk(1,1,1,0,0, 32'h0,        1,c_RR,!c_RR,0,0,0,0,1, c_RR ? c_IA : c_DA, 32'h0, 32'h0);
        tbl[12] = mk(1,1,1,1,0, 32'h55,       1,0,1,c_RR,!c_RR,0,0,1, c_DA,
                     c_RR ? 32'h55 : 32'h0, c_RR ? 32'h0 : 32'h55);
        tbl[13] = mk(1,1,1,1,0, 32'h55,       1,c_RR,!c_RR,0,1,0,0,1, c_RR ? c_IA : c_DA, 32'h0, 32'h55);
        tbl[14] = mk(1,1,1,1,0, 32'h55,       1,0,1,c_RR,!c_RR,0,0,1, c_DA,
                     c_RR ? 32'h55 : 32'h0, c_RR ? 32'h0 : 32'h55);
        tbl[15] = mk(0,0,0,1,0, 32'h55,       0,0,0,0,1,0,0,1, 32'h0, 32'h0, 32'h55);

        repeat (3) @(posedge clk);
        #1 rst_ni = 1'b1;
        @(negedge clk);
        chk("rst_mem_req", -1, 32'(mem_req_o), 32'h0);
        chk("rst_unexp",   -1, 32'(unexp_rsp_o), 32'h0);
        chk("rst_gnts",    -1, {30'h0, instr_gnt_o, data_gnt_o}, 32'h0);

        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1 drive(tbl[i].ir, tbl[i].dr, tbl[i].g, tbl[i].rv, tbl[i].er, tbl[i].rd);
            @(negedge clk);
            chk("mem_req",      i, 32'(mem_req_o),      32'(tbl[i].mreq));
            chk("instr_gnt",    i, 32'(instr_gnt_o),    32'(tbl[i].ig));
            chk("data_gnt",     i, 32'(data_gnt_o),     32'(tbl[i].dg));
            chk("instr_rvalid", i, 32'(instr_rvalid_o), 32'(tbl[i].irv));
            chk("data_rvalid",  i, 32'(data_rvalid_o),  32'(tbl[i].drv));
            chk("instr_err",    i, 32'(instr_err_o),    32'(tbl[i].ierr));
            chk("data_err",     i, 32'(data_err_o),     32'(tbl[i].derr));
            chk("unexp",        i, 32'(unexp_rsp_o),    32'(tbl[i].unexp));
            chk("mem_addr",     i, mem_addr_o,          tbl[i].maddr);
            chk("instr_rdata",  i, instr_rdata_o,       tbl[i].ird);
            chk("data_rdata",   i, data_rdata_o,        tbl[i].drd);
            if (tbl[i].maddr == c_DA) begin
                chk("mem_we_data", i, 32'(mem_we_o), 32'h1);
                chk("mem_be_data", i, 32'(mem_be_o), 32'h3);
                chk("mem_wdata",   i, mem_wdata_o,   c_WD);
            end else if (tbl[i].maddr == c_IA) begin
                chk("mem_we_instr", i, 32'(mem_we_o), 32'h0);
                chk("mem_be_instr", i, 32'(mem_be_o), 32'hF);
            end
        end

        // Fill the FIFO with two fetches, then reset with both outstanding.
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1 drive(1, 0, 1, 0, 0, 32'h0);
            @(negedge clk);
            chk("fill_gnt", 100 + k, 32'(instr_gnt_o), 32'h1);
        end
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("full_block_req", 102 + k, 32'(mem_req_o), 32'h0);
            chk("full_block_gnt", 102 + k, 32'(instr_gnt_o), 32'h0);
        end
        #1 rst_ni = 1'b0;
        #1 chk("async_rst_unexp", 104, 32'(unexp_rsp_o), 32'h0);
        @(posedge clk);
        #1 rst_ni = 1'b1;
        drive(1, 0, 0, 0, 0, 32'h0);
        @(negedge clk);
        chk("post_rst_req", 105, 32'(mem_req_o), 32'h1);
        @(posedge clk);
        #1 drive(0, 0, 0, 1, 0, 32'h77);
        @(negedge clk);
        chk("post_rst_irv",  106, 32'(instr_rvalid_o), 32'h0);
        chk("post_rst_drv",  106, 32'(data_rvalid_o),  32'h0);
        chk("post_rst_rdat", 106, instr_rdata_o,       32'h0);
        @(posedge clk);
        #1 drive(0, 0, 0, 0, 0, 32'h0);
        @(negedge clk);
        chk("post_rst_unexp", 107, 32'(unexp_rsp_o), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
